min_argmin_pipe: RTL and testbench
==================================

// Module: min_argmin_pipe
// PURPOSE
//  Parametrised, pipelined MIN/MAX-with-index reduction over N unsigned W-bit elements.
//  Next generation of the DAC-digital 18-element MIN tree used by the DEM element selector.
//  Adds per-vector MIN/MAX mode, arg-index output, one register per tree level and a
//  valid/ready handshake with back-pressure. Sits between usage counters and the DEM pointer logic.
// PARAMETERS
//  N      18  number of input elements (N >= 2)
//  W      4   element width, unsigned
//  IW     $clog2(N)  index width (derived localparam, not overridable)
//  LVL    $clog2(N)  tree levels = pipeline depth (derived localparam)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_vec     in   N*W    element k at in_vec[k*W +: W]
//  in_mode    in   1      0 = MIN, 1 = MAX; sampled with in_vec
//  in_valid   in   1      in_vec/in_mode valid this cycle
//  in_ready   out  1      block accepts a vector this cycle
//  out_val    out  W      reduced value (min or max)
//  out_idx    out  IW     lowest index k holding out_val
//  out_mode   out  1      mode the result was computed with
//  out_valid  out  1      out_* hold a result
//  out_ready  in   1      downstream accepts result
// BEHAVIOUR
//  - Reset: all stage valids, out_valid = 0; out_val, out_idx, out_mode = 0. in_ready = 1 out of reset.
//  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
//  - Global stall: adv = !out_valid | out_ready. in_ready = adv (combinational).
//    When adv = 1, all LVL stages shift one level; when adv = 0, no stage changes.
//  - Latency: exactly LVL accepted-and-advancing cycles, from input transfer to out_valid
//    (N = 18 -> 5 cycles). Throughput: one vector per cycle while out_ready = 1.
//  - Stage valid bit = valid of the stage before it; bubbles propagate, so a stage without
//    valid data keeps no valid result.
//  - Level l pairs nodes (2j, 2j+1). An odd trailing node is padded with value
//    MIN: {W{1'b1}}, MAX: {W{1'b0}}, and an index above every real index.
//  - Compare node, unsigned: MIN picks b only if b < a, MAX picks b only if b > a;
//    a is the lower-index side, so ties always keep the lower index. A pad never beats a real element.
//  - Mode travels with its vector through the pipeline; mode changes between back-to-back
//    vectors need no flush.
//  - Stalled output holds out_val/idx/mode stable until out_ready.
//  - rst_n low mid-operation: all in-flight vectors are discarded; no partial result is emitted after release.
//  - Data regs need no reset except the output stage; valid bits are reset.
// STRUCTURE
//  - Shared package dac_dig_pkg: MODE_MIN = 1'b0, MODE_MAX = 1'b1 constants and a
//    clog2 helper if the tool flow lacks $clog2.
//  - One sub-module: minmax_idx_node (combinational; inputs a/ai, b/bi, mode; outputs val, idx).
//    The top instantiates it in a generate loop per level, plus level registers and a valid chain.
// TESTING
//  1. N=18, W=4, MIN, in_vec = k+1 for element k, except element 9 = 0
//     -> out_val = 0, out_idx = 9, out_valid 5 cycles after input.
//  2. MAX, all elements 4'hA -> out_val = A, out_idx = 0 (tie to lowest index).
//     Repeat with elements 3 and 17 = F -> idx = 3.
//  3. Back-to-back: 20 random vectors, alternating mode, out_ready = 1
//     -> 20 results in order, 1 per cycle, match reference model.
//  4. Back-pressure: out_ready = 0 for 7 cycles while streaming
//     -> in_ready = 0 once out_valid; out_* stable; no loss or duplication after release.
//  5. N=5 (odd pad), MIN, all elements F -> val = F, idx = 0.
//     MAX, all elements 0 -> val = 0, idx = 0 (pad never wins).
//  6. Assert rst_n low for 1 cycle with 3 vectors in flight -> out_valid = 0 immediately,
//     and no stale result appears afterwards.

Source files
------------

// File: rtl/dac_dig_pkg.sv
// ---------------------------------------------------------------------------
// dac_dig_pkg : shared constants and elaboration helpers for the DAC digital
// Revision    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package dac_dig_pkg;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    // Nodes present at tree level l when starting from n leaves.
    function automatic int nodes_at(input int n, input int l);
        return (n + (1 << l) - 1) >> l;
    endfunction

    // First node of level l inside a flat vector holding levels 0..l-1 ahead of it.
    function automatic int node_off(input int n, input int l);
        int s;
        s = 0;
        for (int m = 0; m < l; m++) begin
            s += nodes_at(n, m);
        end
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/minmax_idx_node.sv
// ---------------------------------------------------------------------------
// minmax_idx_node : one compare node; keeps the a side unless b strictly wins
// Revision        : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module minmax_idx_node
    import dac_dig_pkg::*;
#(
    parameter int W  = 4,
    parameter int IW = 5
) (
    input  logic [W-1:0]  a,
    input  logic [IW-1:0] ai,
    input  logic [W-1:0]  b,
    input  logic [IW-1:0] bi,
    input  logic          mode,
    output logic [W-1:0]  val,
    output logic [IW-1:0] idx
);

    logic take_b;

    assign take_b = (mode == MODE_MAX) ? (b > a) : (b < a);
    assign val    = take_b ? b  : a;
    assign idx    = take_b ? bi : ai;

endmodule

`default_nettype wire

// File: rtl/min_argmin_pipe.sv
// ---------------------------------------------------------------------------
// min_argmin_pipe : pipelined MIN/MAX-with-index tree, one register per level
// Revision        : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module min_argmin_pipe
    import dac_dig_pkg::*;
#(
    parameter  int N   = 18,
    parameter  int W   = 4,
    localparam int IW  = $clog2(N),
    localparam int LVL = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_vec,
    input  logic           in_mode,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   out_val,
    output logic [IW-1:0]  out_idx,
    output logic           out_mode,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int TOT = node_off(N, LVL + 1);
    localparam int RN  = TOT - N;

    // Level l node values as seen by the comparators of level l+1 (level 0 = inputs).
    logic [TOT*W-1:0]  cur_val;
    logic [TOT*IW-1:0] cur_idx;
    logic [RN*W-1:0]   val_d,  val_q;
    logic [RN*IW-1:0]  idx_d,  idx_q;
    logic [LVL:1]      mode_q, vld_q;
    logic              adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign cur_val[N*W-1:0]        = in_vec;
    assign cur_val[TOT*W-1:N*W]    = val_q;
    assign cur_idx[TOT*IW-1:N*IW]  = idx_q;

    for (genvar j = 0; j < N; j++) begin : g_idx0
        assign cur_idx[j*IW +: IW] = IW'(j);
    end

    for (genvar l = 1; l <= LVL; l++) begin : g_lvl
        localparam int PN = nodes_at(N, l - 1);
        localparam int NC = nodes_at(N, l);
        localparam int PO = node_off(N, l - 1);
        localparam int RO = node_off(N, l) - N;

        logic lmode;

        if (l == 1) begin : g_mode_in
            assign lmode = in_mode;
        end else begin : g_mode_stg
            assign lmode = mode_q[l-1];
        end

        for (genvar j = 0; j < NC; j++) begin : g_node
            localparam int A = PO + 2 * j;

            logic [W-1:0]  b_v;
            logic [IW-1:0] b_i;

            if (2 * j + 1 < PN) begin : g_pair
                assign b_v = cur_val[(A+1)*W +: W];
                assign b_i = cur_idx[(A+1)*IW +: IW];
            end else begin : g_pad
                // Pad value can never strictly win, index sits above all real ones.
                assign b_v = (lmode == MODE_MAX) ? {W{1'b0}} : {W{1'b1}};
                assign b_i = {IW{1'b1}};
            end

            minmax_idx_node #(
                .W  (W),
                .IW (IW)
            ) u_node (
                .a    (cur_val[A*W +: W]),
                .ai   (cur_idx[A*IW +: IW]),
                .b    (b_v),
                .bi   (b_i),
                .mode (lmode),
                .val  (val_d[(RO+j)*W +: W]),
                .idx  (idx_d[(RO+j)*IW +: IW])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q  <= '0;
            idx_q  <= '0;
            mode_q <= '0;
            vld_q  <= '0;
        end else if (adv) begin
            val_q <= val_d;
            idx_q <= idx_d;
            for (int l = LVL; l > 1; l--) begin
                mode_q[l] <= mode_q[l-1];
                vld_q[l]  <= vld_q[l-1];
            end
            mode_q[1] <= in_mode;
            vld_q[1]  <= in_valid;
        end
    end

    assign out_val   = cur_val[(TOT-1)*W +: W];
    assign out_idx   = cur_idx[(TOT-1)*IW +: IW];
    assign out_mode  = mode_q[LVL];
    assign out_valid = vld_q[LVL];

endmodule

`default_nettype wire

// File: tb/tb_min_argmin_pipe.sv
// ---------------------------------------------------------------------------
// tb_min_argmin_pipe : directed and scoreboarded checks of min_argmin_pipe
// Revision           : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_min_argmin_pipe;

    localparam int N  = 18;
    localparam int W  = 4;
    localparam int IW = 5;

    typedef struct packed {
        logic [W-1:0]  v;
        logic [IW-1:0] i;
        logic          m;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] in_vec = '0;
    logic           in_mode = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   out_val;
    logic [IW-1:0]  out_idx;
    logic           out_mode;
    logic           out_valid;
    logic           out_ready = 1'b1;

    logic [5*W-1:0] v5 = '0;
    logic           m5 = 1'b0;
    logic           vld5 = 1'b0;
    logic           rdy5;
    logic [W-1:0]   val5;
    logic [2:0]     idx5;
    logic           mode5;
    logic           ov5;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    logic mon_en  = 1'b0;
    exp_t exp_q[$];
    int   out_cyc[$];

    logic          hold_pend = 1'b0;
    logic [W-1:0]  hold_v;
    logic [IW-1:0] hold_i;
    logic          hold_m;

    always #5 clk = ~clk;

    min_argmin_pipe #(.N(N), .W(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vec    (in_vec),
        .in_mode   (in_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_val   (out_val),
        .out_idx   (out_idx),
        .out_mode  (out_mode),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    min_argmin_pipe #(.N(5), .W(W)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vec    (v5),
        .in_mode   (m5),
        .in_valid  (vld5),
        .in_ready  (rdy5),
        .out_val   (val5),
        .out_idx   (idx5),
        .out_mode  (mode5),
        .out_valid (ov5),
        .out_ready (1'b1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [N*W-1:0] vec, input logic m);
        exp_t       e;
        logic [W-1:0] x;
        e.v = vec[W-1:0];
        e.i = '0;
        e.m = m;
        for (int k = 1; k < N; k++) begin
            x = vec[k*W +: W];
            if ((m && x > e.v) || (!m && x < e.v)) begin
                e.v = x;
                e.i = IW'(k);
            end
        end
        return e;
    endfunction

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom_range(0, 15));
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [N*W-1:0] v, input logic m, input exp_t e);
        int guard;
        guard    = 0;
        in_vec   = v;
        in_mode  = m;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("send_ready", 0, 1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic run5(input logic [5*W-1:0] v, input logic m, input logic [W-1:0] ev,
                        input logic [2:0] ei, input string tag);
        int lat;
        v5   = v;
        m5   = m;
        vld5 = 1'b1;
        @(posedge clk);
        #1;
        vld5 = 1'b0;
        lat  = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ov5 && lat < 20);
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_val"}, val5, ev);
        chk({tag, "_idx"}, idx5, ei);
        chk({tag, "_mode"}, mode5, m);
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (mon_en) begin
            if (hold_pend) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_val", out_val, hold_v);
                chk("hold_idx", out_idx, hold_i);
                chk("hold_mode", out_mode, hold_m);
            end
            if (out_valid && !out_ready) chk("bp_in_ready", in_ready, 0);
            hold_pend = out_valid && !out_ready;
            hold_v    = out_val;
            hold_i    = out_idx;
            hold_m    = out_mode;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_val", out_val, e.v);
                    chk("out_idx", out_idx, e.i);
                    chk("out_mode", out_mode, e.m);
                    out_cyc.push_back(cyc);
                end
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N*W-1:0] v;
        exp_t           e;
        int             lat;
        int             s0;
        int             guard;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_val", out_val, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_mode", out_mode, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Test 1: MIN, element k = k+1 except element 9 = 0
        for (int k = 0; k < N; k++) v[k*W +: W] = W'(k + 1);
        v[9*W +: W] = 4'h0;
        send(v, 1'b0, '{v: 4'h0, i: 5'd9, m: 1'b0});
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("t1_latency", lat, 5);
        drain();
        @(posedge clk);
        #1;

        // Test 2: MAX ties resolve to lowest index
        v = {N{4'hA}};
        send(v, 1'b1, '{v: 4'hA, i: 5'd0, m: 1'b1});
        v[3*W +: W]  = 4'hF;
        v[17*W +: W] = 4'hF;
        send(v, 1'b1, '{v: 4'hF, i: 5'd3, m: 1'b1});
        v = {N{4'hF}};
        send(v, 1'b0, '{v: 4'hF, i: 5'd0, m: 1'b0});
        v = {N{4'h5}};
        v[17*W +: W] = 4'h1;
        send(v, 1'b0, '{v: 4'h1, i: 5'd17, m: 1'b0});
        drain();
        @(posedge clk);
        #1;

        // Test 3: 20 back-to-back vectors, alternating mode
        s0 = out_cyc.size();
        for (int n = 0; n < 20; n++) begin
            v = rand_vec();
            send(v, n[0], model(v, n[0]));
        end
        drain();
        chk("t3_count", out_cyc.size() - s0, 20);
        if (out_cyc.size() >= s0 + 20) chk("t3_rate", out_cyc[s0+19] - out_cyc[s0], 19);
        @(posedge clk);
        #1;

        // Test 4: back-pressure for 7 cycles while streaming
        s0 = out_cyc.size();
        fork
            begin
                for (int n = 0; n < 12; n++) begin
                    v = rand_vec();
                    send(v, n[1], model(v, n[1]));
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (7) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("t4_count", out_cyc.size() - s0, 12);
        @(posedge clk);
        #1;

        // Test 5: odd padding on a 5-element instance
        run5({5{4'hF}}, 1'b0, 4'hF, 3'd0, "t5_min_allF");
        run5({5{4'h0}}, 1'b1, 4'h0, 3'd0, "t5_max_all0");
        run5({4'h2, 4'h7, 4'h7, 4'h7, 4'h7}, 1'b0, 4'h2, 3'd4, "t5_min_last");
        run5({4'h9, 4'h3, 4'h3, 4'h3, 4'h3}, 1'b1, 4'h9, 3'd4, "t5_max_last");

        // Test 6: asynchronous reset with three vectors in flight
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            v = rand_vec();
            send(v, 1'b0, model(v, 1'b0));
        end
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("t6_pre_valid", out_valid, 1);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ready", in_ready, 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        mon_en    = 1'b1;
        guard     = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) guard++;
        end
        chk("t6_no_stale", guard, 0);
        @(posedge clk);
        #1;
        v = {N{4'h8}};
        v[11*W +: W] = 4'hC;
        send(v, 1'b1, '{v: 4'hC, i: 5'd11, m: 1'b1});
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
